// File: rtl/lif_dec_pkg.sv
// Shared definitions for the LIF spike decoder.
//   lif_state_e : decoder FSM states (IDLE, ARMED, RUN, REFR)
//   RATE_SAT    : ceiling of the per-window spike count (8-bit rate output)
//   SYNC_DEPTH  : number of flops in the spike_in synchroniser
//   sat_inc8    : saturating increment used by the window spike counter
package lif_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_REFR  = 2'd3
  } lif_state_e;

  localparam logic [7:0] RATE_SAT   = 8'd255;
  localparam int         SYNC_DEPTH = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != RATE_SAT)) return v + 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/lif_spike_sync.sv
// Spike input conditioning: SYNC_DEPTH-flop synchroniser on the asynchronous
// comparator output, then rising-edge detection on the synchronised level.
// Optional macro LIF_DEC_GLITCH_FILTER_EN: the synchronised level must stay
// high for two consecutive cycles before the rise counts as an edge.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (clears all flops)
//   i_spike : asynchronous comparator output
//   o_edge  : one-cycle combinational strobe, one per qualified rising edge
module lif_spike_sync
  import lif_dec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_spike,
  output logic o_edge
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  w_sampled;

  assign w_sampled = r_sync[SYNC_DEPTH-1];

`ifdef LIF_DEC_GLITCH_FILTER_EN
  // r_prev[0] is the previous synchronised sample, r_prev[1] the one before.
  // Edge = low, high, high: a single-cycle high never qualifies.
  logic [1:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_spike};
      r_prev <= {r_prev[0], w_sampled};
    end
  end

  assign o_edge = w_sampled & r_prev[0] & ~r_prev[1];
`else
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_spike};
      r_prev <= w_sampled;
    end
  end

  assign o_edge = w_sampled & ~r_prev;
`endif

endmodule

// File: rtl/lif_spike_decoder.sv
// Digital back end for an analog LIF neuron: turns comparator edges into
// accepted spikes (with refractory blanking), a windowed firing rate and a
// stream of inter-spike intervals.
// Optional macro LIF_DEC_GLITCH_FILTER_EN (in lif_spike_sync) adds a 2-cycle
// high requirement; spike_pulse latency goes from 3 to 4 cycles.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   spike_in           : asynchronous comparator output
//   en                 : decoding enable; dropping it returns the FSM to IDLE
//   refr_cycles        : refractory blanking length after an accepted spike
//   spike_pulse        : one-cycle pulse per accepted spike
//   rate_q, rate_valid : spike count of the last completed window + update strobe
//   isi_data/valid/ready : ISI stream; valid holds with data stable until ready
//   isi_ovf            : sticky, an ISI was dropped because the slot was full
//   o_dbg_state        : current FSM state for observation
// ISI handshake: a transfer happens on a cycle with isi_valid=1 and isi_ready=1;
// isi_valid never drops without a transfer, and a new ISI arriving on a transfer
// cycle replaces the consumed one so isi_valid stays high.
module lif_spike_decoder
  import lif_dec_pkg::*;
#(
  parameter int WIN_LOG2 = 10,
  parameter int ISI_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             en,
  input  logic [3:0]       refr_cycles,
  output logic             spike_pulse,
  output logic [7:0]       rate_q,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             isi_ovf,
  output lif_state_e       o_dbg_state
);

  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [ISI_W-1:0]    ISI_MAX  = '1;

  logic w_edge;

  lif_spike_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_spike (spike_in),
    .o_edge  (w_edge)
  );

  lif_state_e          r_state;
  lif_state_e          w_next_state;
  logic                w_accept;
  logic                w_isi_new;
  logic [3:0]          r_refr_left;
  logic [ISI_W-1:0]    r_isi_cnt;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [7:0]          r_spk_cnt;
  logic [7:0]          w_spk_next;
  logic                w_win_end;
  logic                r_spike_pulse;
  logic [7:0]          r_rate_q;
  logic                r_rate_valid;
  logic [ISI_W-1:0]    r_isi_data;
  logic                r_isi_valid;
  logic                r_isi_ovf;

  // Next-state logic. A zero refractory length means no blanking at all, so
  // an accepted spike then goes straight to RUN instead of through REFR.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_isi_new    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_edge) begin
          w_accept     = 1'b1;
          w_next_state = (refr_cycles == 4'd0) ? ST_RUN : ST_REFR;
        end
      end
      ST_RUN: begin
        if (w_edge) begin
          w_accept     = 1'b1;
          w_isi_new    = 1'b1;
          w_next_state = (refr_cycles == 4'd0) ? ST_RUN : ST_REFR;
        end
      end
      ST_REFR: begin
        if (r_refr_left <= 4'd1) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (!en) begin
      w_next_state = ST_IDLE;
      w_accept     = 1'b0;
      w_isi_new    = 1'b0;
    end
  end

  assign w_win_end  = (r_win_cnt == WIN_LAST);
  assign w_spk_next = sat_inc8(r_spk_cnt, w_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_refr_left   <= 4'd0;
      r_isi_cnt     <= '0;
      r_win_cnt     <= '0;
      r_spk_cnt     <= 8'd0;
      r_spike_pulse <= 1'b0;
      r_rate_q      <= 8'd0;
      r_rate_valid  <= 1'b0;
      r_isi_data    <= '0;
      r_isi_valid   <= 1'b0;
      r_isi_ovf     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_spike_pulse <= w_accept;

      // REFR lasts exactly refr_cycles cycles after the accepting cycle.
      if (w_accept) begin
        r_refr_left <= refr_cycles;
      end else if ((r_state == ST_REFR) && (r_refr_left != 4'd0)) begin
        r_refr_left <= r_refr_left - 4'd1;
      end

      // Loading 1 on an accept makes the count equal the cycle distance to
      // the next accept; it keeps running through REFR.
      if (!en) begin
        r_isi_cnt <= '0;
      end else if (w_accept) begin
        r_isi_cnt <= {{(ISI_W-1){1'b0}}, 1'b1};
      end else if (r_isi_cnt != ISI_MAX) begin
        r_isi_cnt <= r_isi_cnt + 1'b1;
      end

      // Rate window; the spike accepted on the terminal cycle is included.
      r_rate_valid <= en && w_win_end;
      if (!en) begin
        r_win_cnt <= '0;
        r_spk_cnt <= 8'd0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        if (w_win_end) begin
          r_rate_q  <= w_spk_next;
          r_spk_cnt <= 8'd0;
        end else begin
          r_spk_cnt <= w_spk_next;
        end
      end

      // Single-entry ISI slot.
      if (w_isi_new) begin
        if (!r_isi_valid || isi_ready) begin
          r_isi_data  <= r_isi_cnt;
          r_isi_valid <= 1'b1;
        end else begin
          r_isi_ovf <= 1'b1;
        end
      end else if (r_isi_valid && isi_ready) begin
        r_isi_valid <= 1'b0;
      end
      if (!en) r_isi_ovf <= 1'b0;
    end
  end

  assign spike_pulse = r_spike_pulse;
  assign rate_q      = r_rate_q;
  assign rate_valid  = r_rate_valid;
  assign isi_data    = r_isi_data;
  assign isi_valid   = r_isi_valid;
  assign isi_ovf     = r_isi_ovf;
  assign o_dbg_state = r_state;

endmodule
